// File: rtl/pong_button_poller_if.sv
// AXI4-Lite bundle between the pong button poller (master) and the
// pushbutton peripheral register bank (slave).
interface pong_button_poller_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/pong_button_poller.sv
// AXI4-Lite master that polls the pushbutton data register and debounces it.
// Define POLLER_INIT_WR_EN to issue a one-time control-register write after reset.
module pong_button_poller #(
    parameter int          NBTN      = 4,
    parameter int          POLL_DIV  = 1000,
    parameter int          DEB_CNT   = 4,
    parameter logic [31:0] DATA_ADDR = 32'h0000_0000,
    parameter logic [31:0] CTRL_ADDR = 32'h0000_0004,
    parameter logic [31:0] CTRL_INIT = 32'h0000_0001
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    pong_button_poller_if.master m_axi,
    output logic [NBTN-1:0]      btn_state,
    output logic [NBTN-1:0]      btn_press,
    output logic [NBTN-1:0]      btn_release,
    output logic                 bus_err
);

`ifdef POLLER_INIT_WR_EN
    localparam logic [2:0] S_INIT_WR = 3'd0;
    localparam logic [2:0] S_INIT_B  = 3'd1;
`endif
    localparam logic [2:0] S_IDLE    = 3'd2;
    localparam logic [2:0] S_RD_AR   = 3'd3;
    localparam logic [2:0] S_RD_R    = 3'd4;
`ifdef POLLER_INIT_WR_EN
    localparam logic [2:0] S_RESET   = S_INIT_WR;
`else
    localparam logic [2:0] S_RESET   = S_IDLE;
`endif

    localparam logic [31:0] TIMER_RELOAD = 32'(POLL_DIV - 1);
    localparam logic [3:0]  DEB_LAST     = 4'(DEB_CNT - 1);

    logic [2:0]      state_r;
    logic [31:0]     timer_r;
    logic            arvalid_r;
    logic [31:0]     araddr_r;
    logic            rready_r;
    logic [NBTN-1:0] sample_r;
    logic            sample_vld_r;
    logic            err_pend_r;
    logic [NBTN-1:0] btn_state_r;
    logic [NBTN-1:0] press_r;
    logic [NBTN-1:0] release_r;
    logic            bus_err_r;
    logic [3:0]      cnt_r [NBTN];
    logic            unused_s;

`ifdef POLLER_INIT_WR_EN
    logic        awvalid_r;
    logic        wvalid_r;
    logic        bready_r;
    logic [31:0] awaddr_r;
    logic [31:0] wdata_r;
    logic        issued_r;
    logic        aw_done_r;
    logic        w_done_r;
    logic        aw_hs_s;
    logic        w_hs_s;

    assign aw_hs_s        = awvalid_r & m_axi.awready;
    assign w_hs_s         = wvalid_r & m_axi.wready;
    assign m_axi.awvalid  = awvalid_r;
    assign m_axi.wvalid   = wvalid_r;
    assign m_axi.bready   = bready_r;
    assign m_axi.awaddr   = awaddr_r;
    assign m_axi.wdata    = wdata_r;
    assign unused_s       = &{1'b0, m_axi.rdata};
`else
    assign m_axi.awvalid  = 1'b0;
    assign m_axi.wvalid   = 1'b0;
    assign m_axi.bready   = 1'b0;
    assign m_axi.awaddr   = 32'h0000_0000;
    assign m_axi.wdata    = 32'h0000_0000;
    assign unused_s       = &{1'b0, m_axi.rdata, m_axi.awready, m_axi.wready,
                              m_axi.bvalid, m_axi.bresp};
`endif

    assign m_axi.awprot  = 3'b000;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_r;
    assign m_axi.araddr  = araddr_r;
    assign m_axi.rready  = rready_r;
    assign btn_state     = btn_state_r;
    assign btn_press     = press_r;
    assign btn_release   = release_r;
    assign bus_err       = bus_err_r;

    // Bus sequencer: optional init write, then periodic reads of the data register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r      <= S_RESET;
            timer_r      <= TIMER_RELOAD;
            arvalid_r    <= 1'b0;
            araddr_r     <= 32'h0000_0000;
            rready_r     <= 1'b0;
            sample_r     <= {NBTN{1'b0}};
            sample_vld_r <= 1'b0;
            err_pend_r   <= 1'b0;
`ifdef POLLER_INIT_WR_EN
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
            awaddr_r     <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            issued_r     <= 1'b0;
            aw_done_r    <= 1'b0;
            w_done_r     <= 1'b0;
`endif
        end else begin
            sample_vld_r <= 1'b0;
            err_pend_r   <= 1'b0;
            case (state_r)
`ifdef POLLER_INIT_WR_EN
                S_INIT_WR: begin
                    if (!issued_r) begin
                        issued_r  <= 1'b1;
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        awaddr_r  <= CTRL_ADDR;
                        wdata_r   <= CTRL_INIT;
                    end else begin
                        // AW and W complete independently, in any order.
                        if (aw_hs_s) begin
                            awvalid_r <= 1'b0;
                            aw_done_r <= 1'b1;
                        end
                        if (w_hs_s) begin
                            wvalid_r <= 1'b0;
                            w_done_r <= 1'b1;
                        end
                        if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
                            state_r  <= S_INIT_B;
                            bready_r <= 1'b1;
                        end
                    end
                end
                S_INIT_B: begin
                    if (m_axi.bvalid) begin
                        bready_r   <= 1'b0;
                        err_pend_r <= (m_axi.bresp != 2'b00);
                        state_r    <= S_IDLE;
                        timer_r    <= TIMER_RELOAD;
                    end
                end
`endif
                S_IDLE: begin
                    if (timer_r == 32'd0) begin
                        state_r   <= S_RD_AR;
                        arvalid_r <= 1'b1;
                        araddr_r  <= DATA_ADDR;
                    end else begin
                        timer_r <= timer_r - 32'd1;
                    end
                end
                S_RD_AR: begin
                    if (m_axi.arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (m_axi.rvalid) begin
                        rready_r <= 1'b0;
                        state_r  <= S_IDLE;
                        timer_r  <= TIMER_RELOAD;
                        // A faulty response is reported and its data dropped.
                        if (m_axi.rresp == 2'b00) begin
                            sample_r     <= m_axi.rdata[NBTN-1:0];
                            sample_vld_r <= 1'b1;
                        end else begin
                            err_pend_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= S_RESET;
                    timer_r <= TIMER_RELOAD;
                end
            endcase
        end
    end

    // Per-bit debounce: a level change is accepted after DEB_CNT differing samples in a row.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            btn_state_r <= {NBTN{1'b0}};
            press_r     <= {NBTN{1'b0}};
            release_r   <= {NBTN{1'b0}};
            bus_err_r   <= 1'b0;
            for (int i = 0; i < NBTN; i++) begin
                cnt_r[i] <= 4'd0;
            end
        end else begin
            bus_err_r <= err_pend_r;
            press_r   <= {NBTN{1'b0}};
            release_r <= {NBTN{1'b0}};
            if (sample_vld_r) begin
                for (int i = 0; i < NBTN; i++) begin
                    if (sample_r[i] == btn_state_r[i]) begin
                        cnt_r[i] <= 4'd0;
                    end else if (cnt_r[i] == DEB_LAST) begin
                        cnt_r[i]       <= 4'd0;
                        btn_state_r[i] <= sample_r[i];
                        press_r[i]     <= sample_r[i];
                        release_r[i]   <= ~sample_r[i];
                    end else begin
                        cnt_r[i] <= cnt_r[i] + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pong_button_poller.sv
// Directed self-checking bench for pong_button_poller acting as a scripted AXI4-Lite slave.
// Init-write checks apply when POLLER_INIT_WR_EN is defined; otherwise no write may appear.
module tb_pong_button_poller;
    logic       ACLK = 1'b0;
    logic       ARESET = 1'b1;
    logic [3:0] btn_state;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       bus_err;

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  next_ar_exp = 0;
    bit  next_vld = 1'b0;
    int  t_rel;
    bit  ok;

    pong_button_poller_if m_axi ();

    pong_button_poller dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .m_axi       (m_axi.master),
        .btn_state   (btn_state),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .bus_err     (bus_err)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_arvalid(output bit found);
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge ACLK);
            found = m_axi.arvalid;
        end
        if (!found) check_eq("arvalid_timeout", 32'd0, 32'd1);
    endtask

    // Zero-wait read: ARREADY as soon as ARVALID is seen, RVALID on the next cycle.
    task automatic serve_read(input logic [3:0] data, input logic [1:0] resp);
        bit seen;
        wait_arvalid(seen);
        if (seen) begin
            if (next_vld) check_eq("poll_start", cyc, next_ar_exp);
            next_ar_exp = cyc + 1002;
            next_vld    = 1'b1;
            check_eq("araddr", m_axi.araddr, 32'h0000_0000);
            check_eq("no_rewrite", {m_axi.awvalid, m_axi.wvalid}, 32'd0);
            m_axi.arready = 1'b1;
            @(negedge ACLK);
            m_axi.arready = 1'b0;
            check_eq("arvalid_drop", m_axi.arvalid, 32'd0);
            check_eq("rready_up", m_axi.rready, 32'd1);
            m_axi.rdata  = {28'hFFF_FFFF, data};
            m_axi.rresp  = resp;
            m_axi.rvalid = 1'b1;
            @(negedge ACLK);
            m_axi.rvalid = 1'b0;
            m_axi.rresp  = 2'b00;
            check_eq("rready_drop", m_axi.rready, 32'd0);
        end
    endtask

    // One poll plus the outputs one cycle after the read and one cycle later.
    task automatic poll(input string tag, input logic [3:0] data, input logic [1:0] resp,
                        input logic [3:0] st, input logic [3:0] pr, input logic [3:0] rl);
        serve_read(data, resp);
        @(negedge ACLK);
        check_eq({tag, "_state"}, btn_state, st);
        check_eq({tag, "_press"}, btn_press, pr);
        check_eq({tag, "_release"}, btn_release, rl);
        check_eq({tag, "_bus_err"}, bus_err, (resp != 2'b00) ? 32'd1 : 32'd0);
        @(negedge ACLK);
        check_eq({tag, "_state_hold"}, btn_state, st);
        check_eq({tag, "_press_clr"}, btn_press, 32'd0);
        check_eq({tag, "_release_clr"}, btn_release, 32'd0);
        check_eq({tag, "_bus_err_clr"}, bus_err, 32'd0);
    endtask

    // Init write with independent AW/W ready delays, then a write response.
    task automatic serve_write(input int aw_delay, input int w_delay, input logic [1:0] resp);
        bit seen, aw_d, w_d, aw_hs, w_hs;
        seen = 1'b0; aw_d = 1'b0; w_d = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge ACLK);
            seen = m_axi.awvalid;
        end
        check_eq("awvalid_up", seen, 32'd1);
        check_eq("wvalid_up", m_axi.wvalid, 32'd1);
        check_eq("awaddr", m_axi.awaddr, 32'h0000_0004);
        check_eq("wdata", m_axi.wdata, 32'h0000_0001);
        check_eq("wstrb", m_axi.wstrb, 32'hF);
        check_eq("awprot", m_axi.awprot, 32'd0);
        for (int k = 0; k < 20 && !(aw_d && w_d); k++) begin
            m_axi.awready = !aw_d && (k >= aw_delay);
            m_axi.wready  = !w_d && (k >= w_delay);
            aw_hs = m_axi.awready && m_axi.awvalid;
            w_hs  = m_axi.wready && m_axi.wvalid;
            @(negedge ACLK);
            if (aw_hs) begin
                aw_d = 1'b1;
                check_eq("awvalid_drop", m_axi.awvalid, 32'd0);
            end
            if (w_hs) begin
                w_d = 1'b1;
                check_eq("wvalid_drop", m_axi.wvalid, 32'd0);
            end
            if (w_d && !aw_d) check_eq("awvalid_held", m_axi.awvalid, 32'd1);
            if (aw_d && !w_d) check_eq("wvalid_held", m_axi.wvalid, 32'd1);
        end
        m_axi.awready = 1'b0;
        m_axi.wready  = 1'b0;
        check_eq("write_done", {aw_d, w_d}, 32'd3);
        check_eq("bready_up", m_axi.bready, 32'd1);
        m_axi.bvalid = 1'b1;
        m_axi.bresp  = resp;
        @(negedge ACLK);
        m_axi.bvalid = 1'b0;
        m_axi.bresp  = 2'b00;
        next_ar_exp  = cyc + 1000;
        next_vld     = 1'b1;
        check_eq("bready_drop", m_axi.bready, 32'd0);
        @(negedge ACLK);
        check_eq("b_bus_err", bus_err, (resp != 2'b00) ? 32'd1 : 32'd0);
        @(negedge ACLK);
        check_eq("b_bus_err_clr", bus_err, 32'd0);
    endtask

    initial begin
        m_axi.awready = 1'b0;
        m_axi.wready  = 1'b0;
        m_axi.bvalid  = 1'b0;
        m_axi.bresp   = 2'b00;
        m_axi.arready = 1'b0;
        m_axi.rvalid  = 1'b0;
        m_axi.rdata   = 32'h0000_0000;
        m_axi.rresp   = 2'b00;
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        check_eq("rst_valids", {m_axi.awvalid, m_axi.wvalid, m_axi.arvalid}, 32'd0);
        check_eq("rst_readys", {m_axi.bready, m_axi.rready}, 32'd0);
        check_eq("rst_awaddr", m_axi.awaddr, 32'd0);
        check_eq("rst_wdata", m_axi.wdata, 32'd0);
        check_eq("rst_araddr", m_axi.araddr, 32'd0);
        check_eq("rst_btn", {btn_state, btn_press, btn_release}, 32'd0);
        check_eq("rst_bus_err", bus_err, 32'd0);

        ARESET = 1'b0;
        t_rel  = cyc;
`ifdef POLLER_INIT_WR_EN
        serve_write(0, 0, 2'b00);
`else
        next_ar_exp = t_rel + 1000;
        next_vld    = 1'b1;
`endif

        // Press of button 1 needs four agreeing samples.
        poll("deb1", 4'b0010, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        poll("deb2", 4'b0010, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        poll("deb3", 4'b0010, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        poll("deb4", 4'b0010, 2'b00, 4'b0010, 4'b0010, 4'b0000);
        // Release of button 1.
        poll("rel1", 4'b0000, 2'b00, 4'b0010, 4'b0000, 4'b0000);
        poll("rel2", 4'b0000, 2'b00, 4'b0010, 4'b0000, 4'b0000);
        poll("rel3", 4'b0000, 2'b00, 4'b0010, 4'b0000, 4'b0000);
        poll("rel4", 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0010);
        // Glitch restarts the count: press lands only on the 4th sample after it.
        poll("gl1", 4'b0010, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        poll("gl2", 4'b0010, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        poll("gl3", 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        poll("gl4", 4'b0010, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        poll("gl5", 4'b0010, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        poll("gl6", 4'b0010, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        poll("gl7", 4'b0010, 2'b00, 4'b0010, 4'b0010, 4'b0000);
        // Faulty read mid-count must leave state and counters alone.
        poll("er1", 4'b0000, 2'b00, 4'b0010, 4'b0000, 4'b0000);
        poll("er2", 4'b0000, 2'b00, 4'b0010, 4'b0000, 4'b0000);
        poll("erx", 4'b1111, 2'b10, 4'b0010, 4'b0000, 4'b0000);
        poll("er3", 4'b0000, 2'b00, 4'b0010, 4'b0000, 4'b0000);
        poll("er4", 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0010);
        // Several buttons changing together pulse in the same cycle.
        poll("mb1", 4'b1101, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        poll("mb2", 4'b1101, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        poll("mb3", 4'b1101, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        poll("mb4", 4'b1101, 2'b00, 4'b1101, 4'b1101, 4'b0000);

        // Reset while ARVALID waits on a stalled ARREADY.
        wait_arvalid(ok);
        m_axi.arready = 1'b0;
        @(negedge ACLK);
        check_eq("stall_arvalid", m_axi.arvalid, 32'd1);
        ARESET = 1'b1;
        @(negedge ACLK);
        check_eq("mid_rst_arvalid", m_axi.arvalid, 32'd0);
        check_eq("mid_rst_state", btn_state, 32'd0);
        check_eq("mid_rst_rready", m_axi.rready, 32'd0);
        ARESET   = 1'b0;
        t_rel    = cyc;
        next_vld = 1'b0;
`ifdef POLLER_INIT_WR_EN
        serve_write(3, 0, 2'b10);
`else
        next_ar_exp = t_rel + 1000;
        next_vld    = 1'b1;
`endif
        poll("post", 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pong_button_poller.md
# pong_button_poller

AXI4-Lite master that sequences all access to the pushbutton peripheral's register bank in the PongGame SoC. After reset it optionally writes a control word, then polls the button data register at a fixed interval. It debounces each sampled bit and hands the game logic a stable button vector plus one-cycle press/release pulses, so paddle logic never touches the bus.

## Interface
Parameters:
- NBTN, 4: number of buttons, mapped to data register bits [NBTN-1:0]; range 1..32.
- POLL_DIV, 1000: idle cycles between polls; must be ≥ 2.
- DEB_CNT, 4: consecutive identical samples required to change a button's state; range 1..15.
- DATA_ADDR, 32'h0000_0000: byte address of the button data register.
- CTRL_ADDR, 32'h0000_0004: byte address of the control register.
- CTRL_INIT, 32'h0000_0001: value written to CTRL_ADDR after reset.

Ports (clock and reset first):
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  reset; synchronous, active-high.
- M_AXI_AWADDR  out  32  write address.
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_AWVALID / M_AXI_AWREADY  out/in  1  write-address handshake.
- M_AXI_WDATA  out  32  write data.
- M_AXI_WSTRB  out  4  constant 4'hF.
- M_AXI_WVALID / M_AXI_WREADY  out/in  1  write-data handshake.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID / M_AXI_BREADY  in/out  1  write-response handshake.
- M_AXI_ARADDR  out  32  read address; always DATA_ADDR.
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_ARVALID / M_AXI_ARREADY  out/in  1  read-address handshake.
- M_AXI_RDATA  in  32  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID / M_AXI_RREADY  in/out  1  read-data handshake.
- btn_state  out  NBTN  debounced button levels.
- btn_press  out  NBTN  one-cycle pulse on each 0→1 state change.
- btn_release  out  NBTN  one-cycle pulse on each 1→0 state change.
- bus_err  out  1  one-cycle pulse on a non-OKAY BRESP or RRESP.

## Operation
- FSM states: INIT_WR, INIT_B, IDLE, RD_AR, RD_R.
- INIT_WR:
  - AWVALID and WVALID rise together, with AWADDR=CTRL_ADDR and WDATA=CTRL_INIT.
  - Each valid drops on its own handshake. Once both handshakes are done, go to INIT_B.
  - Handshakes may complete in the same cycle or in either order.
- INIT_B: BREADY=1. On BVALID, go to IDLE. If BRESP≠2'b00, pulse bus_err. The write is never retried.
- IDLE:
  - The poll timer loads POLL_DIV-1 on entry and decrements each cycle.
  - When the timer reads 0, go to RD_AR.
- RD_AR: ARVALID=1 until ARREADY, then go to RD_R.
- RD_R:
  - RREADY=1. On RVALID, capture RDATA[NBTN-1:0] as the sample, then go to IDLE.
  - If RRESP≠OKAY, pulse bus_err and discard the sample. Debounce state is untouched.
- Debounce, per bit i:
  - If sample[i]==btn_state[i], clear cnt[i].
  - Otherwise increment cnt[i]. When cnt[i] reaches DEB_CNT, toggle btn_state[i], clear cnt[i], and pulse press[i] or release[i].
  - Counters are 4 bits and saturate-free, since DEB_CNT ≤ 15.
- Once VALID is asserted, it and its address/data are held stable until handshake. There is no abort path.
- Multiple bits may change on the same sample. Their pulses are asserted in the same cycle.

## Timing
- Reset values:
  - All VALID/READY outputs 0. AWADDR, WDATA and ARADDR 0.
  - btn_state 0; press, release and bus_err 0; debounce counters 0.
  - FSM enters INIT_WR, or IDLE when the Configuration macro is undefined.
- ARESET asserted mid-transaction:
  - All outputs return to reset values on the next edge.
  - Bus-side recovery is the interconnect's reset responsibility, since it shares ARESET.
- Handshakes: a transfer occurs on an edge where VALID&READY=1. READY-before-VALID is accepted.
- Outputs are registered. No combinational path from any input to any output.
- Poll period:
  - POLL_DIV cycles in IDLE.
  - Plus one cycle in RD_AR at minimum, plus one cycle in RD_R at minimum.
  - Zero-wait slave: POLL_DIV+2 cycles start-to-start.
- Sample to output: btn_state, press and release update on the edge after the RVALID&RREADY edge, i.e. one-cycle latency.
- bus_err asserts on the edge after the faulty response handshake, for exactly one cycle.

## Configuration
- POLLER_INIT_WR_EN.
- Defined: INIT_WR and INIT_B exist as above. The first poll follows the write response.
- Undefined:
  - INIT states are not compiled. The FSM resets into IDLE.
  - AWVALID, WVALID and BREADY are tied 0. AWADDR and WDATA are tied 0.
  - CTRL_ADDR and CTRL_INIT are unused.

## Test plan
- Init write, macro defined, zero-wait slave:
  - Reset released: one write is issued with AWADDR=0x4, WDATA=0x1.
  - The first ARVALID follows 1000 idle cycles after BVALID.
- AW/W ordering: slave asserts WREADY 3 cycles before AWREADY -> WVALID drops after its handshake while AWVALID holds; exactly one write is issued.
- Debounce with NBTN=4, DEB_CNT=4, button data 4'b0010:
  - Polls 1-3 return 4'b0010: no change.
  - Poll 4 returns 4'b0010: btn_state=4'b0010 with a one-cycle btn_press=4'b0010.
  - A later run of 4 polls returning 4'b0000 gives btn_release=4'b0010.
- Glitch: samples 0010,0010,0000,0010,0010 -> btn_state stays 0000; the counter restarts after the mismatch.
- Error: RRESP=2'b10 on a read returning 4'b1111 -> bus_err pulses once; btn_state and the counters are unchanged.
- Reset mid-read: ARESET asserted while ARVALID=1 with ARREADY held low -> ARVALID=0 and btn_state=0 on the next edge; the init write repeats after release.
